// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the up/down counter family.
// Functions work on a 32-bit word; narrower callers zero-extend in and truncate out.
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    function automatic gray_word_t bin2gray(input gray_word_t x);
        return x ^ (x >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero-extended upper bits leave the result unchanged.
    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_updown_counter_if.sv
// Control and status bundle between a controller and the Gray up/down counter.
interface gray_updown_counter_if #(
    parameter int WIDTH = 3
);
    logic             clear;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] gray_out;
    logic [WIDTH-1:0] bin_out;
    logic             at_limit;
    logic             wrap_pulse;

    modport master (
        output clear, en, up, load, load_val,
        input  gray_out, bin_out, at_limit, wrap_pulse
    );

    modport slave (
        input  clear, en, up, load, load_val,
        output gray_out, bin_out, at_limit, wrap_pulse
    );
endinterface

// File: rtl/gray_limit_detect.sv
// Combinational end-of-range detector: flags the step that would leave the binary range.
module gray_limit_detect #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] bin,
    input  logic             up,
    output logic             at_limit
);

    logic is_max;
    logic is_min;

    assign is_max   = (bin == {WIDTH{1'b1}});
    assign is_min   = (bin == {WIDTH{1'b0}});
    assign at_limit = up ? is_max : is_min;

endmodule

// File: rtl/gray_updown_counter.sv
// Parametrised Gray-code up/down counter with clear/load, wrap or saturate, and wrap pulse.
// gray_out is registered from the next binary value so it never glitches downstream.
module gray_updown_counter
    import gray_pkg::*;
#(
    parameter int             WIDTH     = 3,
    parameter logic [WIDTH-1:0] RESET_BIN = {WIDTH{1'b1}},
    parameter bit             WRAP      = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    gray_updown_counter_if.slave   bus
);

    localparam logic [WIDTH-1:0] BIN_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] BIN_MIN  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] BIN_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] GRAY_RST = WIDTH'(bin2gray(gray_word_t'(RESET_BIN)));

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q;

    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;
    logic             wrap_next;
    logic             at_limit;

    gray_limit_detect #(
        .WIDTH (WIDTH)
    ) u_limit (
        .bin      (bin_q),
        .up       (bus.up),
        .at_limit (at_limit)
    );

    // Priority: clear over load over count; only a wrap step raises the pulse.
    always_comb begin
        bin_next  = bin_q;
        wrap_next = 1'b0;
        if (bus.clear) begin
            bin_next = RESET_BIN;
        end else if (bus.load) begin
            bin_next = bus.load_val;
        end else if (bus.en) begin
            if (!at_limit) begin
                bin_next = bus.up ? (bin_q + BIN_ONE) : (bin_q - BIN_ONE);
            end else if (WRAP) begin
                bin_next  = bus.up ? BIN_MIN : BIN_MAX;
                wrap_next = 1'b1;
            end
        end
    end

    assign gray_next = WIDTH'(bin2gray(gray_word_t'(bin_next)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_q  <= RESET_BIN;
            gray_q <= GRAY_RST;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_next;
            gray_q <= gray_next;
            wrap_q <= wrap_next;
        end
    end

    assign bus.bin_out    = bin_q;
    assign bus.gray_out   = gray_q;
    assign bus.wrap_pulse = wrap_q;
    assign bus.at_limit   = at_limit;

endmodule
